// File: rtl/rotate_pkg.sv
// Shared types and Q-format helpers for the rotate_scan_ctrl block.
package rotate_pkg;

    localparam int unsigned FRAC_DEFAULT = 12;
    localparam int unsigned ONE_Q        = 1 << FRAC_DEFAULT;
    localparam int unsigned HALF_Q       = 1 << (FRAC_DEFAULT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StMap,
        StRead,
        StEmit,
        StDone
    } rot_state_e;

    // Image centre in Q.frac: (n-1)/2 scaled by 2^frac.
    function automatic int q_center(input int unsigned n, input int unsigned frac);
        return int'((n - 1) << (frac - 1));
    endfunction

    // One half in Q.frac, used for round-half-up.
    function automatic int q_half(input int unsigned frac);
        return int'(1 << (frac - 1));
    endfunction

endpackage

// File: rtl/rotate_coord_dda.sv
// Incremental source-coordinate tracker for inverse-mapped rotation.
// Holds the row-base and current source coordinates, seeds them from the
// latched cos/sin and steps them per destination column or row.
module rotate_coord_dda
    import rotate_pkg::*;
#(
    parameter int unsigned ROWS   = 242,
    parameter int unsigned COLS   = 247,
    parameter int unsigned FRAC   = FRAC_DEFAULT,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     init,
    input  logic                     col_step,
    input  logic                     row_step,
    input  logic signed [15:0]       cos_in,
    input  logic signed [15:0]       sin_in,
    output logic        [ADDR_W-1:0] ix,
    output logic        [ADDR_W-1:0] iy,
    output logic                     in_bounds
);

    localparam int unsigned PW = ACC_W + 16;

    localparam logic signed [ACC_W-1:0] CX     = ACC_W'(q_center(COLS, FRAC));
    localparam logic signed [ACC_W-1:0] CY     = ACC_W'(q_center(ROWS, FRAC));
    localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(q_half(FRAC));
    localparam logic signed [ACC_W-1:0] COLS_S = ACC_W'(COLS);
    localparam logic signed [ACC_W-1:0] ROWS_S = ACC_W'(ROWS);

    logic signed [15:0]      cos_r_q, sin_r_q;
    logic signed [ACC_W-1:0] sx_q, sy_q, sxr_q, syr_q;
    logic signed [ACC_W-1:0] sx_d, sy_d, sxr_d, syr_d;
    logic signed [ACC_W-1:0] cos_e, sin_e;
    logic signed [PW-1:0]    cos_cx, sin_cy, sin_cx, cos_cy;
    logic signed [ACC_W-1:0] init_x, init_y;
    logic signed [ACC_W-1:0] ix_full, iy_full;

    assign cos_e = ACC_W'(cos_r_q);
    assign sin_e = ACC_W'(sin_r_q);

    assign cos_cx = PW'(cos_r_q) * PW'(CX);
    assign sin_cy = PW'(sin_r_q) * PW'(CY);
    assign sin_cx = PW'(sin_r_q) * PW'(CX);
    assign cos_cy = PW'(cos_r_q) * PW'(CY);

    // Source position of destination (0,0): centre minus rotated centre.
    assign init_x = CX - ACC_W'(cos_cx >>> FRAC) - ACC_W'(sin_cy >>> FRAC);
    assign init_y = CY + ACC_W'(sin_cx >>> FRAC) - ACC_W'(cos_cy >>> FRAC);

    // Round half up; arithmetic shift floors negatives.
    assign ix_full = (sx_q + HALF) >>> FRAC;
    assign iy_full = (sy_q + HALF) >>> FRAC;

    assign in_bounds = !ix_full[ACC_W-1] && (ix_full < COLS_S) &&
                       !iy_full[ACC_W-1] && (iy_full < ROWS_S);
    assign ix = ix_full[ADDR_W-1:0];
    assign iy = iy_full[ADDR_W-1:0];

    // Next accumulator values: seed, column step, or row step with reload.
    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        sxr_d = sxr_q;
        syr_d = syr_q;
        if (init) begin
            sxr_d = init_x;
            syr_d = init_y;
            sx_d  = init_x;
            sy_d  = init_y;
        end else if (col_step) begin
            sx_d = sx_q + cos_e;
            sy_d = sy_q - sin_e;
        end else if (row_step) begin
            sxr_d = sxr_q + sin_e;
            syr_d = syr_q + cos_e;
            sx_d  = sxr_q + sin_e;
            sy_d  = syr_q + cos_e;
        end
    end

    // Coefficient latch and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_r_q <= '0;
            sin_r_q <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            sxr_q   <= '0;
            syr_q   <= '0;
        end else begin
            if (load) begin
                cos_r_q <= cos_in;
                sin_r_q <= sin_in;
            end
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            sxr_q <= sxr_d;
            syr_q <= syr_d;
        end
    end

endmodule

// File: rtl/rotate_scan_ctrl.sv
// Frame sequencer for inverse-mapped image rotation. Walks destination
// pixels row-major, reads in-bounds source pixels, substitutes FILL for
// out-of-bounds ones and streams the result over valid/ready.
// Optional: define ROT_OOB_COUNT_EN to add the oob_count output.
module rotate_scan_ctrl
    import rotate_pkg::*;
#(
    parameter int unsigned ROWS   = 242,
    parameter int unsigned COLS   = 247,
    parameter int unsigned FRAC   = FRAC_DEFAULT,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter logic [7:0]  FILL   = 8'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [15:0]       cos_q,
    input  logic signed [15:0]       sin_q,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_req,
    output logic        [ADDR_W-1:0] rd_addr,
    input  logic                     rd_ack,
    input  logic        [7:0]        rd_data,
    output logic                     px_valid,
    output logic        [7:0]        px_data,
    output logic                     px_last,
    input  logic                     px_ready
`ifdef ROT_OOB_COUNT_EN
    ,
    output logic        [ADDR_W-1:0] oob_count
`endif
);

    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    rot_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pix_q, pix_d;
    logic              dda_load, dda_init, col_step, row_step;
    logic [ADDR_W-1:0] ix, iy;
    logic              in_bounds;
    logic              last_px;

    rotate_coord_dda #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .FRAC   (FRAC),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) u_dda (
        .clk       (clk),
        .rst       (rst),
        .load      (dda_load),
        .init      (dda_init),
        .col_step  (col_step),
        .row_step  (row_step),
        .cos_in    (cos_q),
        .sin_in    (sin_q),
        .ix        (ix),
        .iy        (iy),
        .in_bounds (in_bounds)
    );

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    // Next-state, counter and datapath control decode.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        pix_d    = pix_q;
        dda_load = 1'b0;
        dda_init = 1'b0;
        col_step = 1'b0;
        row_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dda_load = 1'b1;
                    state_d  = StInit;
                end
            end
            StInit: begin
                dda_init = 1'b1;
                x_d      = '0;
                y_d      = '0;
                state_d  = StMap;
            end
            StMap: begin
                if (in_bounds) begin
                    addr_d  = iy * COLS_A + ix;
                    state_d = StRead;
                end else begin
                    pix_d   = FILL;
                    state_d = StEmit;
                end
            end
            StRead: begin
                if (rd_ack) begin
                    pix_d   = rd_data;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (px_ready) begin
                    if (last_px) begin
                        state_d = StDone;
                    end else begin
                        state_d = StMap;
                        if (x_q != X_LAST) begin
                            x_d      = x_q + 1'b1;
                            col_step = 1'b1;
                        end else begin
                            x_d      = '0;
                            y_d      = y_q + 1'b1;
                            row_step = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, destination position and output holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
        end
    end

    assign busy     = (state_q == StInit) || (state_q == StMap) ||
                      (state_q == StRead) || (state_q == StEmit);
    assign done     = (state_q == StDone);
    assign rd_req   = (state_q == StRead);
    assign rd_addr  = addr_q;
    assign px_valid = (state_q == StEmit);
    assign px_data  = pix_q;
    assign px_last  = (state_q == StEmit) && last_px;

`ifdef ROT_OOB_COUNT_EN
    logic              oob_px_q;
    logic [ADDR_W-1:0] oob_cnt_q;

    // Tag each pixel in MAP; count fill pixels as their handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_px_q  <= 1'b0;
            oob_cnt_q <= '0;
        end else begin
            if (state_q == StMap) begin
                oob_px_q <= !in_bounds;
            end
            if ((state_q == StIdle) && start) begin
                oob_cnt_q <= '0;
            end else if ((state_q == StEmit) && px_ready && oob_px_q) begin
                oob_cnt_q <= oob_cnt_q + 1'b1;
            end
        end
    end

    assign oob_count = oob_cnt_q;
`endif

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Directed bench for rotate_scan_ctrl on a small 4x5 frame.
module tb_rotate_scan_ctrl;

    localparam int          ROWS   = 4;
    localparam int          COLS   = 5;
    localparam int          FRAC   = 12;
    localparam int          ADDR_W = 16;
    localparam int          ACC_W  = 32;
    localparam logic [7:0]  FILL   = 8'hA5;
    localparam int          N      = ROWS * COLS;
    localparam longint      CX     = longint'(COLS - 1) * (longint'(1) << (FRAC - 1));
    localparam longint      CY     = longint'(ROWS - 1) * (longint'(1) << (FRAC - 1));
    localparam longint      HALF   = longint'(1) << (FRAC - 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic signed [15:0]       cos_in = '0;
    logic signed [15:0]       sin_in = '0;
    logic                     busy, done, rd_req, rd_ack;
    logic        [ADDR_W-1:0] rd_addr;
    logic        [7:0]        rd_data;
    logic                     px_valid, px_last;
    logic        [7:0]        px_data;
    logic                     px_ready = 1'b0;
`ifdef ROT_OOB_COUNT_EN
    logic        [ADDR_W-1:0] oob_count;
`endif

    int     n_assert = 0;
    int     n_fail   = 0;
    int     max_ack  = 0;
    int     ack_lim  = 0;
    int     ack_wait = 0;
    longint bx, by, cc, ss;

    always #5 clk = ~clk;

    rotate_scan_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .FRAC   (FRAC),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W),
        .FILL   (FILL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cos_q    (cos_in),
        .sin_q    (sin_in),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .px_valid (px_valid),
        .px_data  (px_data),
        .px_last  (px_last),
        .px_ready (px_ready)
`ifdef ROT_OOB_COUNT_EN
        ,
        .oob_count (oob_count)
`endif
    );

    function automatic logic [7:0] src_pix(input logic [ADDR_W-1:0] a);
        return (a[7:0] * 8'd37) ^ 8'h5A;
    endfunction

    // Source frame buffer: data valid with the ack, ack after a random wait.
    assign rd_data = src_pix(rd_addr);
    assign rd_ack  = rd_req && (ack_wait >= ack_lim);

    always @(posedge clk) begin
        if (rd_ack) begin
            ack_wait <= 0;
            ack_lim  <= int'($urandom_range(unsigned'(max_ack), 0));
        end else if (rd_req) begin
            ack_wait <= ack_wait + 1;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_rd_req"}, longint'(rd_req), 0);
        check({tag, "_rd_addr"}, longint'(rd_addr), 0);
        check({tag, "_px_valid"}, longint'(px_valid), 0);
        check({tag, "_px_data"}, longint'(px_data), 0);
        check({tag, "_px_last"}, longint'(px_last), 0);
    endtask

    // Direct (non-incremental) inverse map of destination pixel p.
    function automatic void model_px(input int p, output bit inb, output longint addr,
                                     output logic [7:0] data);
        longint x, y, sx, sy, ix, iy;
        x  = longint'(p % COLS);
        y  = longint'(p / COLS);
        sx = bx + x * cc + y * ss;
        sy = by - x * ss + y * cc;
        ix = (sx + HALF) >>> FRAC;
        iy = (sy + HALF) >>> FRAC;
        inb  = (ix >= 0) && (ix < COLS) && (iy >= 0) && (iy < ROWS);
        addr = inb ? (iy * COLS + ix) : -1;
        data = inb ? src_pix(ADDR_W'(addr)) : FILL;
    endfunction

    task automatic run_frame(input logic signed [15:0] c, input logic signed [15:0] s,
                             input int rdy_pct, input int ack_max, input int abort_at,
                             input int exp_cycles, output longint first_addr,
                             output longint last_addr);
        int          p, cyc, budget, oob_n;
        bit          fin, inb;
        longint      eaddr;
        logic [7:0]  edata;

        cc = longint'(c);
        ss = longint'(s);
        bx = CX - ((cc * CX) >>> FRAC) - ((ss * CY) >>> FRAC);
        by = CY + ((ss * CX) >>> FRAC) - ((cc * CY) >>> FRAC);
        oob_n = 0;
        for (int i = 0; i < N; i++) begin
            model_px(i, inb, eaddr, edata);
            if (!inb) oob_n++;
        end
        max_ack    = ack_max;
        first_addr = -1;
        last_addr  = -1;
        budget     = N * 14 + 20;

        @(negedge clk);
        start    = 1'b1;
        cos_in   = c;
        sin_in   = s;
        px_ready = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        cos_in = 16'sh7000;
        sin_in = -16'sh0800;
        check("busy_after_start", longint'(busy), 1);
        cyc = 1;
        p   = 0;
        fin = 1'b0;

        while (!fin) begin
            check("req_valid_exclusive", longint'(rd_req & px_valid), 0);
            model_px(p, inb, eaddr, edata);
            if (rd_req) begin
                check("rd_addr", longint'(rd_addr), eaddr);
                if (first_addr < 0) first_addr = longint'(rd_addr);
                last_addr = longint'(rd_addr);
            end
            if (px_valid) begin
                check("px_data", longint'(px_data), longint'(edata));
                check("px_last", longint'(px_last), longint'(p == N - 1));
            end
            if (done) begin
                check("pixels_at_done", longint'(p), longint'(N));
                check("busy_at_done", longint'(busy), 0);
                if (exp_cycles > 0) check("frame_cycles", longint'(cyc), longint'(exp_cycles));
                fin = 1'b1;
            end else if (abort_at >= 0 && p == abort_at && px_valid) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("abort");
`ifdef ROT_OOB_COUNT_EN
                check("abort_oob_count", longint'(oob_count), 0);
`endif
                @(negedge clk);
                check("abort_no_done", longint'(done), 0);
                rst = 1'b0;
                fin = 1'b1;
            end else if (cyc > budget) begin
                check("frame_timeout", longint'(cyc), longint'(budget));
                fin = 1'b1;
            end
            if (!fin) begin
                px_ready = (int'($urandom_range(99, 0)) < rdy_pct);
                if (px_valid && px_ready) p++;
                start = (cyc == 5);
                @(negedge clk);
                cyc++;
            end
        end

        start    = 1'b0;
        px_ready = 1'b0;
        if (abort_at < 0) begin
            @(negedge clk);
            check("done_single_pulse", longint'(done), 0);
            check("busy_after_done", longint'(busy), 0);
            check("px_valid_after_done", longint'(px_valid), 0);
`ifdef ROT_OOB_COUNT_EN
            check("oob_count", longint'(oob_count), longint'(oob_n));
`endif
        end
    endtask

    initial begin
        longint fa, la;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
`ifdef ROT_OOB_COUNT_EN
        check("reset_oob_count", longint'(oob_count), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("idle");

        // 0 deg: identity scan, 3 cycles per pixel plus INIT and DONE.
        run_frame(16'sd4096, 16'sd0, 100, 0, -1, 62, fa, la);
        check("id_first_addr", fa, 0);
        check("id_last_addr", la, 19);

        // 180 deg: reversed scan.
        run_frame(-16'sd4096, 16'sd0, 100, 0, -1, 62, fa, la);
        check("r180_first_addr", fa, 19);
        check("r180_last_addr", la, 0);

        // 90 deg: column x=0 falls outside (iy=4), 4 fill pixels at 2 cycles.
        run_frame(16'sd0, 16'sd4096, 100, 0, -1, 58, fa, la);
        check("r90_first_addr", fa, 16);
        check("r90_last_addr", la, 4);

        // 45 deg: mixed in/out of bounds.
        run_frame(16'sd2896, 16'sd2896, 100, 0, -1, 0, fa, la);

        // Backpressure and delayed acks.
        run_frame(16'sd4096, 16'sd0, 50, 5, -1, 0, fa, la);
        check("bp_first_addr", fa, 0);
        check("bp_last_addr", la, 19);
        run_frame(16'sd2896, -16'sd2896, 50, 5, -1, 0, fa, la);

        // Reset mid-frame, then a clean restart.
        run_frame(16'sd4096, 16'sd0, 100, 0, 7, 0, fa, la);
        run_frame(16'sd4096, 16'sd0, 100, 0, -1, 0, fa, la);
        check("restart_first_addr", fa, 0);
        check("restart_last_addr", la, 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
